// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Converter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } bcd_state_t;

    // A BCD digit at or above this value would exceed 9 after the next shift.
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    // Correction added before the shift so the digit carries into its neighbour.
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction: adds 3 when the digit is 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Pre-shift correction for one BCD digit.
    always_comb begin
        digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ_ADD) : digit_in;
    end

endmodule : bcd_digit_adj

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Values above 10^DIGITS-1 saturate to all nines and raise ovf.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(WIDTH + 1);
    localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;

    bcd_state_t         state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   shift_q,    shift_d;
    logic [BCD_W-1:0]   scratch_q,  scratch_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               ovf_q,      ovf_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;

    // Scratch digits after the add-3 correction, ready to be shifted.
    logic [BCD_W-1:0]   adj_w;

    // One correction cell per BCD digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch_q[4*g +: 4]),
            .digit_out (adj_w[4*g +: 4])
        );
    end

    // Next-state logic: accept, shift WIDTH times, then publish the result.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d    = bin_in;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(WIDTH);
                    ovf_pend_d = (32'(bin_in) > MAX_VAL);
                    busy_d     = 1'b1;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                // The top scratch bit falls off; saturation covers that range.
                {scratch_d, shift_d} = {adj_w, shift_q} << 1;
                cnt_d                = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scratch_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign bcd_out = bcd_q;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] bcd_out;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for exactly one edge (the accepting edge E0).
    task automatic start_conv(input logic [13:0] val);
        bin_in = val;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Wait for done; returns cycles waited, or -1 if the bound expired.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Reference conversion by division, independent of the shift algorithm.
    function automatic logic [16:0] ref_bcd(input int v);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Full conversion with latency, busy, result and single-pulse checks.
    task automatic run_conv(input string tag, input logic [13:0] val,
                            input logic [15:0] exp_bcd, input logic exp_ovf);
        int lat;
        start_conv(val);
        check({tag, "_busy_e0"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'd15);
        check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [16:0] r;
        logic [13:0] v;

        reset  = 1'b0;
        start  = 1'b0;
        bin_in = '0;

        // 1. Reset and idle behaviour.
        repeat (3) tick();
        reset = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        check("rst_bcd",  32'(bcd_out), 32'h0000);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        check("idle_no_done", 32'(ndone), 32'd0);

        // 2. Basic conversions.
        run_conv("c1234", 14'd1234, 16'h1234, 1'b0);
        run_conv("c0",    14'd0,    16'h0000, 1'b0);
        run_conv("c9999", 14'd9999, 16'h9999, 1'b0);

        // 3. Saturation and recovery.
        run_conv("c10000", 14'd10000, 16'h9999, 1'b1);
        run_conv("c16383", 14'd16383, 16'h9999, 1'b1);
        run_conv("c42",    14'd42,    16'h0042, 1'b0);

        // 4. start and bin_in changes while busy are ignored.
        start_conv(14'd500);
        repeat (4) tick();
        bin_in = 14'd777;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = 14'd123;
        wait_done(lat);
        check("ign_latency", 32'(lat), 32'd10);
        check("ign_bcd", 32'(bcd_out), 32'h0500);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        check("ign_single_done", 32'(ndone), 32'd0);

        // Leave ovf set so the reset below has something to clear.
        run_conv("c12000", 14'd12000, 16'h9999, 1'b1);

        // 5. Reset mid-conversion aborts.
        start_conv(14'd8765);
        repeat (6) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd",  32'(bcd_out), 32'h0000);
        check("abort_ovf",  32'(ovf), 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run_conv("c31", 14'd31, 16'h0031, 1'b0);

        // 6. Back-to-back: new start accepted in the done cycle.
        start_conv(14'd4321);
        wait_done(lat);
        check("b2b_lat1", 32'(lat), 32'd15);
        check("b2b_bcd1", 32'(bcd_out), 32'h4321);
        start_conv(14'd9);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(lat);
        check("b2b_lat2", 32'(lat), 32'd15);
        check("b2b_bcd2", 32'(bcd_out), 32'h0009);

        // Random sweep against the division-based reference.
        for (int i = 0; i < 10; i++) begin
            v = 14'($urandom_range(0, 16383));
            r = ref_bcd(int'(v));
            run_conv($sformatf("rnd%0d_%0d", i, v), v, r[15:0], r[16]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
